// File: rtl/io_sequencer_pkg.sv
// Shared types for the picoMIPS I/O sequencer: debounce FSM states and run counter width.
package io_seq_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    PRESSED  = 2'd2,
    REL_DB   = 2'd3
  } io_state_t;

  localparam int RUN_CW = 4;
endpackage

// File: rtl/io_sequencer_if.sv
// Board/decoder-facing signal bundle of the I/O sequencer.
interface io_sequencer_if
  import io_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic              button_raw;
  logic [DW-1:0]     switches;
  logic              retrieve_switch;
  logic              retrieve_wave;
  logic              led_status_in;
  logic [DW-1:0]     result_in;
  logic [DW-1:0]     wave_data_in;
  logic              branch_status;
  logic [DW-1:0]     data_in_sel;
  logic [AW-1:0]     wave_addr;
  logic [DW-1:0]     leds;
  logic              leds_valid;
  logic [RUN_CW-1:0] run_count;

  modport master (
    output button_raw, switches, retrieve_switch, retrieve_wave,
           led_status_in, result_in, wave_data_in,
    input  branch_status, data_in_sel, wave_addr, leds, leds_valid, run_count
  );

  modport slave (
    input  button_raw, switches, retrieve_switch, retrieve_wave,
           led_status_in, result_in, wave_data_in,
    output branch_status, data_in_sel, wave_addr, leds, leds_valid, run_count
  );
endinterface

// File: rtl/io_sequencer_btn_debounce.sv
// Run-button synchroniser and press/release debounce FSM; emits branch_status and a new_run pulse.
module btn_debounce
  import io_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic nReset,
  input  logic button_raw,
  output logic branch_status,
  output logic new_run
);
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DC_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic            btn_m, btn_s;
  io_state_t       state_q, state_d;
  logic [CW-1:0]   dbc_q, dbc_d;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= button_raw;
      btn_s <= btn_m;
    end
  end

  // new_run is combinational so the top applies run-start effects on the PRESSED entry edge.
  always_comb begin
    state_d = state_q;
    dbc_d   = dbc_q;
    new_run = 1'b0;
    case (state_q)
      IDLE: if (btn_s) begin
        state_d = PRESS_DB;
        dbc_d   = '0;
      end
      PRESS_DB: begin
        if (!btn_s) state_d = IDLE;
        else if (dbc_q == DC_MAX) begin
          state_d = PRESSED;
          new_run = 1'b1;
        end else dbc_d = dbc_q + CW'(1);
      end
      PRESSED: if (!btn_s) begin
        state_d = REL_DB;
        dbc_d   = '0;
      end
      REL_DB: begin
        if (btn_s) state_d = PRESSED;
        else if (dbc_q == DC_MAX) state_d = IDLE;
        else dbc_d = dbc_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= IDLE;
      dbc_q         <= '0;
      branch_status <= 1'b0;
    end else begin
      state_q       <= state_d;
      dbc_q         <= dbc_d;
      branch_status <= (state_d == PRESSED) || (state_d == REL_DB);
    end
  end
endmodule

// File: rtl/io_sequencer.sv
// picoMIPS external I/O sequencer: debounced run button, LDI/LDW operand mux, wave address, LED latch.
module io_sequencer
  import io_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WAVE_DEPTH      = 256,
  parameter int AW              = $clog2(WAVE_DEPTH),
  parameter int DW              = 8
) (
  input  logic           clk,
  input  logic           nReset,
  io_sequencer_if.slave  bus
);
  logic          new_run;
  logic [DW-1:0] switch_latch;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk           (clk),
    .nReset        (nReset),
    .button_raw    (bus.button_raw),
    .branch_status (bus.branch_status),
    .new_run       (new_run)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      switch_latch  <= '0;
      bus.run_count <= '0;
    end else if (new_run) begin
      switch_latch  <= bus.switches;
      bus.run_count <= bus.run_count + RUN_CW'(1);
    end
  end

  // A run start restarts the sample stream even if LDW fires on the same edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)                bus.wave_addr <= '0;
    else if (new_run)           bus.wave_addr <= '0;
    else if (bus.retrieve_wave) bus.wave_addr <= (bus.wave_addr == AW'(WAVE_DEPTH - 1))
                                                 ? '0 : bus.wave_addr + AW'(1);
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bus.leds       <= '0;
      bus.leds_valid <= 1'b0;
    end else if (bus.led_status_in) begin
      bus.leds       <= bus.result_in;
      bus.leds_valid <= 1'b1;
    end else if (new_run) begin
      bus.leds_valid <= 1'b0;
    end
  end

  always_comb begin
    bus.data_in_sel = '0;
    if (bus.retrieve_switch)    bus.data_in_sel = switch_latch;
    else if (bus.retrieve_wave) bus.data_in_sel = bus.wave_data_in;
  end

  // LDI and LDW together means the decoder is broken.
  a_retrieve_onehot: assert property (@(posedge clk) disable iff (!nReset)
    !(bus.retrieve_switch && bus.retrieve_wave));
endmodule

// File: tb/tb_io_sequencer.sv
// Bench for io_sequencer: directed checks plus randomized traffic against a stable-sample-count model.
module tb_io_sequencer;
  localparam int DC = 4, WD = 8, AW = 3, DW = 8;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  io_sequencer_if #(.DW(DW), .AW(AW)) bus();

  io_sequencer #(.DEBOUNCE_CYCLES(DC), .WAVE_DEPTH(WD), .AW(AW), .DW(DW)) u_dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  int n_cmp = 0, n_err = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a press is accepted after DC+1 consecutive 1-samples of the 2-flop-delayed button
  // while released; a release after DC+1 consecutive 0-samples while pressed.
  logic          m_s1 = 0, m_s2 = 0, m_pressed = 0, m_valid = 0;
  int            m_run1 = 0, m_run0 = 0, m_addr = 0, m_cnt = 0;
  logic [DW-1:0] m_sw = 0, m_leds = 0;

  always @(posedge clk or negedge nReset) begin
    logic samp, nr;
    if (!nReset) begin
      m_s1 = 0; m_s2 = 0; m_pressed = 0; m_valid = 0;
      m_run1 = 0; m_run0 = 0; m_addr = 0; m_cnt = 0; m_sw = 0; m_leds = 0;
    end else begin
      samp = m_s2; m_s2 = m_s1; m_s1 = bus.button_raw;
      m_run1 = samp ? m_run1 + 1 : 0;
      m_run0 = samp ? 0 : m_run0 + 1;
      nr = 0;
      if (!m_pressed && m_run1 == DC + 1) begin m_pressed = 1; nr = 1; end
      else if (m_pressed && m_run0 == DC + 1) m_pressed = 0;
      if (nr) begin m_sw = bus.switches; m_cnt = (m_cnt + 1) % 16; end
      if (nr) m_addr = 0;
      else if (bus.retrieve_wave) m_addr = (m_addr + 1) % WD;
      if (bus.led_status_in) begin m_leds = bus.result_in; m_valid = 1; end
      else if (nr) m_valid = 0;
    end
  end

  always @(posedge clk) begin
    logic [DW-1:0] exp_sel;
    #2;
    exp_sel = bus.retrieve_switch ? m_sw : (bus.retrieve_wave ? bus.wave_data_in : '0);
    chk("branch_status", bus.branch_status, m_pressed);
    chk("data_in_sel", bus.data_in_sel, exp_sel);
    chk("wave_addr", bus.wave_addr, m_addr);
    chk("leds", bus.leds, m_leds);
    chk("leds_valid", bus.leds_valid, m_valid);
    chk("run_count", bus.run_count, m_cnt);
  end

  task automatic chk_all_zero(string nm);
    chk({nm, "_branch"}, bus.branch_status, 0);
    chk({nm, "_sel"}, bus.data_in_sel, 0);
    chk({nm, "_addr"}, bus.wave_addr, 0);
    chk({nm, "_leds"}, bus.leds, 0);
    chk({nm, "_valid"}, bus.leds_valid, 0);
    chk({nm, "_runcnt"}, bus.run_count, 0);
  endtask

  task automatic release_btn();
    bus.button_raw = 0;
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_rise(string nm);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1 chk({nm, "_early"}, bus.branch_status, 0);
    end
    @(posedge clk); #1 chk({nm, "_rise"}, bus.branch_status, 1);
  endtask

  initial begin
    bus.button_raw = 0; bus.switches = 0; bus.retrieve_switch = 0; bus.retrieve_wave = 0;
    bus.led_status_in = 0; bus.result_in = 0; bus.wave_data_in = 8'hC3;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    nReset = 1;
    repeat (2) @(negedge clk);

    // First press: rise 7 edges after the button edge, switches latched.
    bus.switches = 8'hA5; bus.button_raw = 1;
    expect_rise("t1");
    chk("t1_run_count", bus.run_count, 1);
    @(negedge clk); bus.switches = 8'h5A; bus.retrieve_switch = 1;
    #1 chk("t1_sel", bus.data_in_sel, 8'hA5);
    @(negedge clk); bus.retrieve_switch = 0;
    bus.retrieve_wave = 1; repeat (3) @(negedge clk); bus.retrieve_wave = 0;
    #1 chk("t3_addr_pre", bus.wave_addr, 3);

    // Release bounce while pressed.
    bus.button_raw = 0; repeat (2) @(negedge clk); bus.button_raw = 1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1 chk("t3_hold", bus.branch_status, 1);
    end
    chk("t3_run_count", bus.run_count, 1);
    chk("t3_addr", bus.wave_addr, 3);

    // LED capture, then a new run clears only leds_valid.
    @(negedge clk); bus.led_status_in = 1; bus.result_in = 8'h3C;
    @(posedge clk); #1 chk("led_val", bus.leds, 8'h3C); chk("led_valid", bus.leds_valid, 1);
    @(negedge clk); bus.led_status_in = 0; bus.result_in = 0;
    release_btn();
    chk("rel_branch", bus.branch_status, 0);
    bus.button_raw = 1;
    expect_rise("t5");
    chk("t5_valid", bus.leds_valid, 0); chk("t5_leds", bus.leds, 8'h3C);
    chk("t5_run_count", bus.run_count, 2); chk("t5_addr", bus.wave_addr, 0);

    // Nine wave pulses: 1..7, 0, 1.
    @(negedge clk); bus.retrieve_wave = 1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1 chk("wave_wrap", bus.wave_addr, k % WD);
    end
    @(negedge clk); bus.retrieve_wave = 0;

    // New run coinciding with LDW and DISP.
    release_btn();
    bus.button_raw = 1; bus.retrieve_wave = 1; bus.led_status_in = 1; bus.result_in = 8'h77;
    expect_rise("t4");
    chk("t4_addr_clear", bus.wave_addr, 0); chk("t4_valid", bus.leds_valid, 1);
    chk("t4_leds", bus.leds, 8'h77); chk("t4_run_count", bus.run_count, 3);
    @(negedge clk); bus.retrieve_wave = 0; bus.led_status_in = 0;

    // Press bounce: 1,1,0 then held.
    release_btn();
    bus.button_raw = 1; repeat (2) @(negedge clk);
    bus.button_raw = 0; @(negedge clk);
    bus.button_raw = 1;
    expect_rise("t2");
    chk("t2_run_count", bus.run_count, 4);

    // Reset mid-PRESS_DB.
    release_btn();
    bus.button_raw = 1;
    repeat (4) @(posedge clk);
    #3 nReset = 0;
    #1 chk_all_zero("rst_db");
    @(negedge clk); nReset = 1;
    expect_rise("t6");
    chk("t6_run_count", bus.run_count, 1);

    // Reset mid-run.
    @(negedge clk); bus.led_status_in = 1; bus.result_in = 8'h99; bus.retrieve_wave = 1;
    @(negedge clk); bus.led_status_in = 0; bus.retrieve_wave = 0;
    @(posedge clk); #3 nReset = 0;
    #1 chk_all_zero("rst_run");
    @(negedge clk); nReset = 1; bus.button_raw = 0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      @(negedge clk);
      if ($urandom_range(7) == 0) bus.button_raw = ~bus.button_raw;
      sel = int'($urandom_range(3));
      bus.retrieve_switch = (sel == 1);
      bus.retrieve_wave   = (sel == 2);
      bus.led_status_in   = ($urandom_range(3) == 0);
      bus.result_in       = DW'($urandom);
      bus.wave_data_in    = DW'($urandom);
      bus.switches        = DW'($urandom);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_sequencer.md
Name: io_sequencer

Overview:
- Sequences the picoMIPS core's external I/O handshake.
- Synchronises and debounces the run button, then presents the result as branch_status to the decoder's BRA instruction.
- Captures the switch operand for LDI with retrieve_switch, and steps the wave-sample ROM address for LDW with retrieve_wave.
- Latches DISP results onto the LEDs.
- Sits between board I/O and the core's data-in mux / decoder.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronised samples needed to accept a press or a release (minimum 2).
- WAVE_DEPTH, 256: number of wave ROM entries; address wraps after WAVE_DEPTH-1.
- AW, $clog2(WAVE_DEPTH): wave address width.
- DW, 8: data width of switches, wave samples and LEDs.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- button_raw  in  1  unsynchronised run button, 1 = pressed.
- switches  in  DW  raw slide switches.
- retrieve_switch  in  1  decoder: LDI executing this cycle.
- retrieve_wave  in  1  decoder: LDW executing this cycle.
- led_status_in  in  1  decoder LED_status, 1 = DISP or BRA with branch_status=1.
- result_in  in  DW  ALU result this cycle.
- wave_data_in  in  DW  combinational ROM data at wave_addr.
- branch_status  out  1  debounced button state to decoder.
- data_in_sel  out  DW  operand to core data-in mux: switch_latch if retrieve_switch, else wave_data_in if retrieve_wave, else 0.
- wave_addr  out  AW  wave ROM address.
- leds  out  DW  displayed value.
- leds_valid  out  1  leds holds a result from the current run.
- run_count  out  4  number of accepted presses, modulo 16.

Behaviour:
- Reset state (nReset=0, asynchronous): all outputs 0; FSM in IDLE; synchroniser flops, debounce counter and switch_latch are 0.
- Synchroniser: two flops; btn_s is the second stage. Press detection therefore lags button_raw by 2 cycles.
- FSM states, with dbc = debounce counter:
  - IDLE: if btn_s=1, go to PRESS_DB and set dbc=0.
  - PRESS_DB:
    - btn_s=0: go to IDLE.
    - btn_s=1 and dbc==DEBOUNCE_CYCLES-1: go to PRESSED.
    - otherwise dbc++.
  - PRESSED: if btn_s=0, go to REL_DB and set dbc=0.
  - REL_DB:
    - btn_s=1: go to PRESSED (a bounce, with no new-run side effects).
    - btn_s=0 and dbc==DEBOUNCE_CYCLES-1: go to IDLE.
    - otherwise dbc++.
- branch_status is registered and equals 1 exactly while the state is PRESSED or REL_DB.
- Entry to PRESSED from PRESS_DB (a new run) has these effects on the same edge:
  - switch_latch <= switches.
  - wave_addr <= 0.
  - leds_valid <= 0.
  - run_count++ (wraps 15 to 0).
- Re-entry to PRESSED from REL_DB has none of these effects.
- Wave counter: on each cycle with retrieve_wave=1, wave_addr increments; WAVE_DEPTH-1 wraps to 0. If a new-run clear coincides with retrieve_wave, the clear wins and wave_addr=0.
- data_in_sel is combinational, with zero latency to the core.
  - Priority: retrieve_switch over retrieve_wave.
  - If both are 1, the condition is an illegal decoder output. Assert it in simulation and select the switch path.
- LEDs: on a cycle with led_status_in=1, leds <= result_in and leds_valid <= 1; the value holds until the next capture.
  - If a capture coincides with new-run entry, the capture wins for leds_valid (=1); leds = result_in.
- Reset asserted mid-debounce or mid-run returns every output to 0 immediately, without waiting for a clock edge.
- Latency summary:
  - Button edge to branch_status: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - retrieve_wave to new wave_addr: 1 cycle.
  - led_status_in to leds: 1 cycle.

Decomposition:
- Package io_seq_pkg holds:
  - the FSM state enum io_state_t {IDLE, PRESS_DB, PRESSED, REL_DB};
  - a localparam for the run_count width (4).
- One natural sub-module: btn_debounce (synchroniser, FSM, dbc). Its outputs are branch_status and a one-cycle new_run pulse.
- The top level holds the wave counter, the LED latch and the data_in_sel mux.

Test Plan (DEBOUNCE_CYCLES=4, WAVE_DEPTH=8):
- Reset, then button_raw=1 held with switches=8'hA5:
  - branch_status rises exactly 7 cycles after the button edge;
  - switch_latch=8'hA5 and run_count=1;
  - retrieve_switch=1 gives data_in_sel=8'hA5.
- Bounce: button_raw=1 for 2 cycles, 0 for 1, then held 1:
  - no early branch_status;
  - it rises 7 cycles after the final rising edge.
- Release bounce while PRESSED: btn 0 for 2 cycles, then 1:
  - branch_status stays 1 throughout;
  - run_count unchanged; wave_addr is not cleared.
- Nine retrieve_wave pulses after a new run: wave_addr reads 1…7, 0, 1. A new-run entry coinciding with retrieve_wave gives wave_addr=0.
- led_status_in=1 with result_in=8'h3C:
  - next cycle leds=8'h3C, leds_valid=1;
  - the next new-run press clears leds_valid but leds holds 8'h3C.
- nReset=0 asserted mid-PRESS_DB and mid-run: all outputs go to 0 before the next clock edge. After release, a full debounce is required before branch_status rises.
